// File: rtl/eth_rx_buf_pkg.sv
// eth_rx_buf_pkg: controller states and buffer geometry constants for the Ethernet receive buffer
package eth_rx_buf_pkg;
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t ST_IDLE   = 2'd0;
  localparam rx_state_t ST_RECV   = 2'd1;
  localparam rx_state_t ST_DROP   = 2'd2;
  localparam rx_state_t ST_COMMIT = 2'd3;
  localparam int CRC_LEN = 4;
  localparam int SLOT_HW = 2 ** (13 - 3);
  function automatic int slot_hw(input int addr_w, input int slot_w);
    return 2 ** (addr_w - slot_w);
  endfunction
endpackage

// File: rtl/eth_rx_slot_ring.sv
// eth_rx_slot_ring: frame slot ring with write/read pointers, occupancy and per-slot byte lengths
module eth_rx_slot_ring #(
  parameter int SLOTS  = 8,
  parameter int SLOT_W = $clog2(SLOTS),
  parameter int LEN_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic [LEN_W-1:0]  len,
  input  logic              rel,
  output logic [SLOT_W-1:0] wr_ptr,
  output logic [SLOT_W:0]   used,
  output logic              stat_valid,
  output logic [SLOT_W-1:0] stat_slot,
  output logic [LEN_W-1:0]  stat_len
);
  logic [SLOT_W-1:0] rd_ptr;
  logic [LEN_W-1:0]  len_tab [SLOTS];
  logic              pop;
  assign pop        = rel && used != '0;
  assign stat_valid = used != '0;
  assign stat_slot  = rd_ptr;
  assign stat_len   = len_tab[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      for (int i = 0; i < SLOTS; i++) len_tab[i] <= '0;
    end else begin
      if (commit) begin
        len_tab[wr_ptr] <= len;
        wr_ptr          <= wr_ptr + SLOT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + SLOT_W'(1);
      used <= used + (SLOT_W+1)'(commit) - (SLOT_W+1)'(pop);
    end
  end
endmodule

// File: rtl/eth_rx_buf_ctrl.sv
// eth_rx_buf_ctrl: MAC halfword stream to slotted packet buffer write sequencer with frame drop and CPU status
// Define ETH_RX_CRC_STRIP_EN to report committed lengths without the 4-byte FCS.
module eth_rx_buf_ctrl import eth_rx_buf_pkg::*; #(
  parameter int ADDR_W = 13,
  parameter int SLOTS  = 8,
  parameter int SLOT_W = $clog2(SLOTS),
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [15:0]       rx_data,
  input  logic [1:0]        rx_be,
  input  logic              rx_last,
  input  logic              rx_err,
  output logic              rx_ready,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              rel,
  output logic              stat_valid,
  output logic [SLOT_W-1:0] stat_slot,
  output logic [ADDR_W:0]   stat_len,
  output logic [SLOT_W:0]   used,
  output logic [DROP_W-1:0] drop_cnt
);
  localparam int OFF_W = ADDR_W - SLOT_W;
  localparam int HW    = slot_hw(ADDR_W, SLOT_W);
  rx_state_t         state, nxt;
  logic [OFF_W-1:0]  off, off_cur;
  logic [ADDR_W:0]   bytes, be_cnt, commit_len;
  logic [SLOT_W-1:0] wr_ptr;
  logic              xfer, full, idle, wr, commit, drop_inc, off_end;
  assign rx_ready = state != ST_COMMIT;
  assign xfer     = rx_valid && rx_ready;
  assign idle     = state == ST_IDLE;
  assign full     = used == (SLOT_W+1)'(SLOTS);
  assign commit   = state == ST_COMMIT;
  assign off_cur  = idle ? '0 : off;
  assign off_end  = off == OFF_W'(HW - 1);
  assign be_cnt   = (ADDR_W+1)'(rx_be[0]) + (ADDR_W+1)'(rx_be[1]);
  assign wr       = xfer && ((idle && !full) || state == ST_RECV);
  // A single-halfword frame can also end with an error, so IDLE counts it as dropped too.
  assign drop_inc = xfer && rx_last && ((idle && (full || rx_err)) || (state == ST_RECV && rx_err) || state == ST_DROP);
`ifdef ETH_RX_CRC_STRIP_EN
  assign commit_len = bytes > (ADDR_W+1)'(CRC_LEN) ? bytes - (ADDR_W+1)'(CRC_LEN) : '0;
`else
  assign commit_len = bytes;
`endif
  always_comb begin
    nxt = state;
    if (commit) nxt = ST_IDLE;
    else if (xfer) begin
      case (state)
        ST_IDLE: nxt = full ? (rx_last ? ST_IDLE : ST_DROP) : (rx_last ? (rx_err ? ST_IDLE : ST_COMMIT) : ST_RECV);
        ST_RECV: nxt = rx_last ? (rx_err ? ST_IDLE : ST_COMMIT) : (off_end ? ST_DROP : ST_RECV);
        ST_DROP: nxt = rx_last ? ST_IDLE : ST_DROP;
        default: nxt = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      off      <= '0;
      bytes    <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 2'b00;
      mem_addr <= '0;
      mem_din  <= '0;
      drop_cnt <= '0;
    end else begin
      state  <= nxt;
      mem_en <= wr;
      mem_we <= wr ? rx_be : 2'b00;
      if (wr) begin
        off      <= off_cur + OFF_W'(1);
        bytes    <= (idle ? '0 : bytes) + be_cnt;
        mem_addr <= {wr_ptr, off_cur};
        mem_din  <= rx_data;
      end
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
  eth_rx_slot_ring #(.SLOTS(SLOTS), .SLOT_W(SLOT_W), .LEN_W(ADDR_W + 1)) u_ring (
    .clk        (clk),
    .rst        (rst),
    .commit     (commit),
    .len        (commit_len),
    .rel        (rel),
    .wr_ptr     (wr_ptr),
    .used       (used),
    .stat_valid (stat_valid),
    .stat_slot  (stat_slot),
    .stat_len   (stat_len)
  );
endmodule

// File: tb/tb_eth_rx_buf_ctrl.sv
// tb_eth_rx_buf_ctrl: directed frames with a write scoreboard and status checks for eth_rx_buf_ctrl
module tb_eth_rx_buf_ctrl;
  localparam int ADDR_W = 13;
  localparam int SLOTS  = 8;
  localparam int SLOT_W = 3;
  localparam int HW     = 1024;
`ifdef ETH_RX_CRC_STRIP_EN
  localparam int STRIP = 4;
`else
  localparam int STRIP = 0;
`endif
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        we;
    logic [15:0]       din;
  } wr_t;
  logic              clk = 0, rst = 1;
  logic              rx_valid = 0, rx_last = 0, rx_err = 0, rel = 0;
  logic [15:0]       rx_data = '0;
  logic [1:0]        rx_be = '0;
  logic              rx_ready, mem_en, stat_valid;
  logic [1:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic [SLOT_W-1:0] stat_slot;
  logic [ADDR_W:0]   stat_len;
  logic [SLOT_W:0]   used;
  logic [15:0]       drop_cnt;
  wr_t               q[$];
  int                checks = 0, failures = 0;
  int                m_wr = 0, m_rd = 0, m_used = 0, fid = 0;
  always #5 clk = ~clk;
  eth_rx_buf_ctrl dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_be(rx_be),
    .rx_last(rx_last), .rx_err(rx_err), .rx_ready(rx_ready), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .rel(rel),
    .stat_valid(stat_valid), .stat_slot(stat_slot), .stat_len(stat_len),
    .used(used), .drop_cnt(drop_cnt)
  );
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int exp_len(input int n);
    return n > STRIP ? n - STRIP : 0;
  endfunction
  always @(negedge clk) begin
    if (!rst && mem_en) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %0d we %0d with empty scoreboard", mem_addr, mem_we);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_we", mem_we, e.we);
        check("wr_din", mem_din, e.din);
      end
    end
  end
  task automatic do_reset();
    rst = 1;
    q.delete();
    m_wr = 0; m_rd = 0; m_used = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
  endtask
  task automatic wait_ready();
    for (int k = 0; k < 8 && !rx_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!rx_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: rx_ready 0 expected 1");
    end
  endtask
  task automatic pulse_rel();
    rel = 1;
    if (m_used > 0) begin
      m_used--;
      m_rd = (m_rd + 1) % SLOTS;
    end
    @(posedge clk); #1;
    rel = 0;
  endtask
  task automatic send_frame(input int nbytes, input bit err, input bit rel_at_commit = 0);
    int nhw;
    bit acc, ok;
    nhw = (nbytes + 1) / 2;
    acc = m_used < SLOTS;
    ok  = acc && !err && nhw <= HW;
    for (int i = 0; i < nhw; i++) begin
      logic [1:0]  be;
      logic [15:0] d;
      be = (i == nhw - 1 && nbytes % 2 == 1) ? 2'b01 : 2'b11;
      d  = 16'(fid * 2003 + i);
      rx_valid = 1; rx_data = d; rx_be = be;
      rx_last = i == nhw - 1;
      rx_err  = err && rx_last;
      wait_ready();
      if (acc && i < HW) q.push_back('{addr: ADDR_W'(m_wr * HW + i), we: be, din: d});
      @(posedge clk); #1;
    end
    rx_valid = 0; rx_last = 0; rx_err = 0;
    if (ok) begin
      m_wr = (m_wr + 1) % SLOTS;
      m_used++;
    end
    if (rel_at_commit) begin
      check("in_commit_ready", rx_ready, 0);
      pulse_rel();
    end
    fid++;
  endtask
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_used", used, 0);
    check("rst_stat_valid", stat_valid, 0);
    do_reset();
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_stat_len", stat_len, 0);
    check("rst_ready", rx_ready, 1);
    send_frame(60, 0);
    settle();
    check("a_valid", stat_valid, 1);
    check("a_slot", stat_slot, 0);
    check("a_len", stat_len, exp_len(60));
    check("a_used", used, 1);
    do_reset();
    send_frame(61, 0);
    settle();
    check("b_len", stat_len, exp_len(61));
    check("b_used", used, 1);
    do_reset();
    send_frame(20, 1);
    settle();
    check("c_used", used, 0);
    check("c_valid", stat_valid, 0);
    check("c_drop", drop_cnt, 1);
    send_frame(10, 0);
    settle();
    check("c_slot", stat_slot, 0);
    check("c_len", stat_len, exp_len(10));
    check("c_used2", used, 1);
    do_reset();
    for (int f = 0; f < 9; f++) send_frame(4, 0);
    settle();
    check("d_used", used, 8);
    check("d_drop", drop_cnt, 1);
    check("d_slot", stat_slot, 0);
    check("d_len", stat_len, exp_len(4));
    pulse_rel();
    check("d_rel_slot", stat_slot, 1);
    check("d_rel_used", used, 7);
    do_reset();
    send_frame(2100, 0);
    settle();
    check("e_used", used, 0);
    check("e_drop", drop_cnt, 1);
    send_frame(2, 0);
    settle();
    check("e_slot", stat_slot, 0);
    check("e_used2", used, 1);
    check("e_len", stat_len, exp_len(2));
    do_reset();
    send_frame(8, 0);
    send_frame(10, 0);
    send_frame(12, 0);
    settle();
    check("f_used3", used, 3);
    send_frame(14, 0, 1);
    check("f_used_keep", used, 3);
    check("f_slot", stat_slot, 1);
    check("f_len", stat_len, exp_len(10));
    send_frame(16, 0);
    settle();
    check("f_used4", used, 4);
    repeat (4) pulse_rel();
    check("f_empty", used, 0);
    check("f_slot5", stat_slot, 5);
    pulse_rel();
    check("f_rel_empty_used", used, 0);
    check("f_rel_empty_slot", stat_slot, 5);
    check("f_rel_empty_valid", stat_valid, 0);
    settle();
    check("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
